// File: rtl/cbfp_pkg.sv
// cbfp_pkg -- shared constants and types for the CBFP (convergent block
// floating point) normaliser.
//   Default geometry: 16 samples per beat, 23-bit signed input,
//   11-bit signed output, 64-sample blocks (4 beats per block).
//   Also holds the output sequencer state type and a helper that derives
//   the number of beats per block from the buffer depth and beat width.
package cbfp_pkg;

    localparam int CBFP_ARRAY_SIZE   = 16;
    localparam int CBFP_DIN_SIZE     = 23;
    localparam int CBFP_DOUT_SIZE    = 11;
    localparam int CBFP_BUFFER_DEPTH = 64;

    // Beats per block.
    function automatic int cbfp_nb(input int depth, input int arr);
        return depth / arr;
    endfunction

    localparam int CBFP_NB = cbfp_nb(CBFP_BUFFER_DEPTH, CBFP_ARRAY_SIZE);

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_OUT  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/cbfp_lsc_min.sv
// cbfp_lsc_min -- combinational leading-sign count and minimum over one beat.
//   For every sample it counts the bits below the MSB that equal the MSB
//   (0 and -1 give din_size-1). It then returns the smallest count in the beat.
// Ports:
//   din   : array_size packed signed samples, sample i at [i*din_size +: din_size]
//   g_min : minimum leading-sign count over the beat
module cbfp_lsc_min
    import cbfp_pkg::*;
#(
    parameter int array_size = CBFP_ARRAY_SIZE,
    parameter int din_size   = CBFP_DIN_SIZE
) (
    input  logic [array_size*din_size-1:0] din,
    output logic [$clog2(din_size)-1:0]    g_min
);

    localparam int CW = $clog2(din_size);

    logic [din_size-1:0] x;
    logic [CW-1:0]       cnt;
    logic                run;

    // Count from just below the MSB downward. Stop at the first bit that
    // differs from the sign bit, and keep the running minimum across samples.
    always_comb begin
        g_min = CW'(din_size - 1);
        x     = '0;
        cnt   = '0;
        run   = 1'b0;
        for (int i = 0; i < array_size; i++) begin
            x   = din[i*din_size +: din_size];
            cnt = '0;
            run = 1'b1;
            for (int b = din_size - 2; b >= 0; b--) begin
                if (run && (x[b] == x[din_size-1])) begin
                    cnt = cnt + 1'b1;
                end else begin
                    run = 1'b0;
                end
            end
            if (cnt < g_min) begin
                g_min = cnt;
            end
        end
    end

endmodule

// File: rtl/test_cbfp.sv
// test_cbfp -- block floating point normaliser with ping-pong block buffers.
//   Captures NB beats of array_size samples into one bank of a two-bank
//   buffer and tracks the per-beat minimum leading-sign count g[k].
//   When the last beat of a block arrives (edge E), it stores the block
//   exponent B = min(g). It publishes g[] on zero_cnt at E+1, then replays
//   the block as (x <<< B) truncated to dout_size bits on edges E+2..E+NB+1.
//   Meanwhile, the other bank captures the next block.
//   Optional build macro CBFP_ROUND_EN: round half up before truncation and
//   saturate the positive overflow to the largest output code.
// Ports:
//   clk, rstn  : clock (rising edge), asynchronous active-low reset
//   valid_in   : beat on din_re_p is captured on this edge
//   din_re_p   : array_size signed samples, din_size bits each
//   dout_re_p  : array_size signed scaled samples, 0 when valid_out=0
//   zero_cnt   : per-beat counts g[k] of the last block, zero-extended
//   valid_out  : dout_re_p carries a beat of the current output block
module test_cbfp
    import cbfp_pkg::*;
#(
    parameter int array_size   = CBFP_ARRAY_SIZE,
    parameter int din_size     = CBFP_DIN_SIZE,
    parameter int dout_size    = CBFP_DOUT_SIZE,
    parameter int buffer_depth = CBFP_BUFFER_DEPTH
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             valid_in,
    input  logic [array_size*din_size-1:0]                   din_re_p,
    output logic [array_size*dout_size-1:0]                  dout_re_p,
    output logic [(buffer_depth/array_size)*din_size-1:0]    zero_cnt,
    output logic                                             valid_out
);

    localparam int NB    = cbfp_nb(buffer_depth, array_size);
    localparam int CW    = $clog2(din_size);
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int W_IN  = array_size * din_size;
    localparam int W_OUT = array_size * dout_size;

    // Capture side
    logic [CW-1:0]   g_new;
    logic [CW-1:0]   g_acc;
    logic [CW-1:0]   b_new;
    logic [BW-1:0]   beat_cnt;
    logic            bank;
    logic            last_beat;
    logic            done_q;
    logic            done_bank;

    logic [W_IN-1:0] buf_mem [0:1][0:NB-1];
    logic [CW-1:0]   g_mem   [0:1][0:NB-1];
    logic [CW-1:0]   blk_b   [0:1];

    // Output side
    seq_state_t       state, state_nxt;
    logic [BW-1:0]    out_beat, beat_nxt;
    logic             src_bank;
    logic             emit;
    logic [W_IN-1:0]  rd_beat;
    logic [CW-1:0]    out_b;
    logic [W_OUT-1:0] scaled;
    logic [NB*din_size-1:0] zc_next;

    logic signed [din_size-1:0] sample;
    logic signed [din_size-1:0] shifted;
`ifdef CBFP_ROUND_EN
    localparam logic [din_size:0] RND = {{din_size{1'b0}}, 1'b1} << (din_size - dout_size - 1);
    logic signed [din_size:0] rounded;
`endif

    cbfp_lsc_min #(
        .array_size (array_size),
        .din_size   (din_size)
    ) u_lsc_min (
        .din   (din_re_p),
        .g_min (g_new)
    );

    assign last_beat = (beat_cnt == BW'(NB - 1));

    // The first beat restarts the running minimum, so a block aborted by
    // reset cannot leak its counts into the next block.
    assign b_new = (beat_cnt == '0) ? g_new
                 : ((g_new < g_acc) ? g_new : g_acc);

    // Beat counter and bank select. done_q pulses for one cycle after the
    // closing beat and remembers which bank holds the finished block.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt  <= '0;
            bank      <= 1'b0;
            g_acc     <= '0;
            done_q    <= 1'b0;
            done_bank <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (valid_in) begin
                g_acc <= b_new;
                if (last_beat) begin
                    beat_cnt  <= '0;
                    bank      <= ~bank;
                    done_q    <= 1'b1;
                    done_bank <= bank;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Sample, per-beat count and block exponent storage. No reset is needed
    // because a bank is only read after all of its beats have been written.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            buf_mem[bank][beat_cnt] <= din_re_p;
            g_mem[bank][beat_cnt]   <= g_new;
            if (last_beat) begin
                blk_b[bank] <= b_new;
            end
        end
    end

    // Zero-extend the finished block's per-beat counts for zero_cnt.
    always_comb begin
        zc_next = '0;
        for (int k = 0; k < NB; k++) begin
            zc_next[k*din_size +: din_size] = {{(din_size-CW){1'b0}}, g_mem[done_bank][k]};
        end
    end

    // Output sequencer. The state moves to SEQ_OUT on the edge after the
    // block closes. It then emits one beat per edge. A block that closes
    // while the last beat is going out chains straight into its own beat 0.
    always_comb begin
        state_nxt = state;
        beat_nxt  = out_beat;
        emit      = 1'b0;
        unique case (state)
            SEQ_IDLE: begin
                if (done_q) begin
                    state_nxt = SEQ_OUT;
                    beat_nxt  = '0;
                end
            end
            SEQ_OUT: begin
                emit = 1'b1;
                if (out_beat == BW'(NB - 1)) begin
                    beat_nxt  = '0;
                    state_nxt = done_q ? SEQ_OUT : SEQ_IDLE;
                end else begin
                    beat_nxt = out_beat + 1'b1;
                end
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

    assign rd_beat = buf_mem[src_bank][out_beat];
    assign out_b   = blk_b[src_bank];

    // Scale every sample by the block exponent. B never exceeds any
    // sample's leading-sign count, so the shift cannot overflow.
    always_comb begin
        scaled  = '0;
        sample  = '0;
        shifted = '0;
`ifdef CBFP_ROUND_EN
        rounded = '0;
`endif
        for (int i = 0; i < array_size; i++) begin
            sample  = rd_beat[i*din_size +: din_size];
            shifted = sample <<< out_b;
`ifdef CBFP_ROUND_EN
            rounded = {shifted[din_size-1], shifted} + RND;
            // Adding a positive constant can only overflow upward.
            if (!rounded[din_size] && rounded[din_size-1]) begin
                scaled[i*dout_size +: dout_size] = {1'b0, {(dout_size-1){1'b1}}};
            end else begin
                scaled[i*dout_size +: dout_size] = rounded[din_size-1 -: dout_size];
            end
`else
            scaled[i*dout_size +: dout_size] = shifted[din_size-1 -: dout_size];
`endif
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= SEQ_IDLE;
            out_beat  <= '0;
            src_bank  <= 1'b0;
            valid_out <= 1'b0;
            dout_re_p <= '0;
            zero_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            out_beat  <= beat_nxt;
            valid_out <= emit;
            dout_re_p <= emit ? scaled : '0;
            if (done_q) begin
                src_bank <= done_bank;
                zero_cnt <= zc_next;
            end
        end
    end

endmodule

// File: tb/tb_test_cbfp.sv
// tb_test_cbfp -- randomized scoreboard bench for test_cbfp.
//   The stimulus side drives beats and, when a block closes, pushes the
//   expected output beats (with due cycle) onto a queue. These come from a
//   numeric model of leading-sign count, block minimum and scaling.
//   A monitor running on the falling edge pops each beat the DUT presents
//   and compares it with the next queue entry.
//   Honours CBFP_ROUND_EN in the model.
module tb_test_cbfp;

    localparam int ARR  = 16;
    localparam int DIN  = 23;
    localparam int DOUT = 11;
    localparam int NB   = 4;
    localparam int SH   = DIN - DOUT;
    localparam int WIN  = ARR * DIN;
    localparam int WOUT = ARR * DOUT;
    localparam int WZC  = NB * DIN;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            valid_in = 1'b0;
    logic [WIN-1:0]  din_re_p = '0;
    logic [WOUT-1:0] dout_re_p;
    logic [WZC-1:0]  zero_cnt;
    logic            valid_out;

    typedef struct packed {
        logic [31:0]     due;
        logic            first;
        logic [WOUT-1:0] dout;
        logic [WZC-1:0]  zc;
    } exp_t;

    exp_t           exp_q[$];
    logic [WIN-1:0] blk[NB];
    int             blk_idx = 0;
    int             cyc = 0;
    int             n_vec = 0;
    int             n_err = 0;

    test_cbfp dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .din_re_p  (din_re_p),
        .dout_re_p (dout_re_p),
        .zero_cnt  (zero_cnt),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Largest n such that x * 2^n still fits in DIN signed bits.
    function automatic int model_lsc(input longint x);
        longint lim;
        int     n;
        lim = longint'(1) << (DIN - 1);
        n   = 0;
        while (n < DIN - 1 && x * (longint'(1) << (n + 1)) >= -lim
                           && x * (longint'(1) << (n + 1)) < lim) begin
            n++;
        end
        return n;
    endfunction

    function automatic longint sample_of(input logic [WIN-1:0] beat, input int i);
        logic signed [DIN-1:0] s;
        s = beat[i*DIN +: DIN];
        return longint'(s);
    endfunction

    function automatic logic [DOUT-1:0] model_scale(input longint x, input int b);
        longint p;
        longint q;
        p = x * (longint'(1) << b);
`ifdef CBFP_ROUND_EN
        q = (p + (longint'(1) << (SH - 1))) >>> SH;
        if (q > (longint'(1) << (DOUT - 1)) - 1) q = (longint'(1) << (DOUT - 1)) - 1;
`else
        q = p >>> SH;
`endif
        return q[DOUT-1:0];
    endfunction

    function automatic logic [WIN-1:0] fill_beat(input logic [DIN-1:0] val);
        logic [WIN-1:0] beat;
        for (int i = 0; i < ARR; i++) beat[i*DIN +: DIN] = val;
        return beat;
    endfunction

    // Random sample with a random number of redundant sign bits.
    function automatic logic [DIN-1:0] rand_sample();
        logic signed [DIN-1:0] v;
        v = DIN'($urandom);
        v = v >>> $urandom_range(0, DIN - 1);
        return v;
    endfunction

    function automatic logic [WIN-1:0] rand_beat();
        logic [WIN-1:0] beat;
        for (int i = 0; i < ARR; i++) beat[i*DIN +: DIN] = rand_sample();
        return beat;
    endfunction

    // Record a beat; on the closing beat compute the block result and queue it.
    task automatic model_capture(input logic [WIN-1:0] beat, input int e);
        int              g[NB];
        int              b;
        exp_t            x;
        logic [WZC-1:0]  zc;
        logic [WOUT-1:0] d;
        blk[blk_idx] = beat;
        if (blk_idx == NB - 1) begin
            b = DIN - 1;
            for (int k = 0; k < NB; k++) begin
                g[k] = DIN - 1;
                for (int i = 0; i < ARR; i++) begin
                    if (model_lsc(sample_of(blk[k], i)) < g[k]) g[k] = model_lsc(sample_of(blk[k], i));
                end
                if (g[k] < b) b = g[k];
            end
            zc = '0;
            for (int k = 0; k < NB; k++) zc[k*DIN +: DIN] = DIN'(g[k]);
            for (int k = 0; k < NB; k++) begin
                for (int i = 0; i < ARR; i++) d[i*DOUT +: DOUT] = model_scale(sample_of(blk[k], i), b);
                x.due   = 32'(e + 2 + k);
                x.first = (k == 0);
                x.dout  = d;
                x.zc    = zc;
                exp_q.push_back(x);
            end
            blk_idx = 0;
        end else begin
            blk_idx++;
        end
    endtask

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic apply_beat(input logic [WIN-1:0] beat);
        @(negedge clk);
        valid_in = 1'b1;
        din_re_p = beat;
        model_capture(beat, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            din_re_p = rand_beat();
        end
    endtask

    task automatic check_reset();
        check_output("reset_valid_out", 256'(valid_out), 256'(0));
        check_output("reset_dout", 256'(dout_re_p), 256'(0));
        check_output("reset_zero_cnt", 256'(zero_cnt), 256'(0));
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        check_output("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    // Monitor: every presented beat must match the head of the queue, on
    // time; idle cycles must show zero data and no overdue beat.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstn) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_valid at cycle %0d: got valid_out=1, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("beat_timing", 256'(cyc), 256'(e.due));
                    check_output("beat_data", 256'(dout_re_p), 256'(e.dout));
                    if (e.first) check_output("zero_cnt", 256'(zero_cnt), 256'(e.zc));
                end
            end else begin
                check_output("idle_dout_zero", 256'(dout_re_p), 256'(0));
                if (exp_q.size() != 0 && int'(exp_q[0].due) <= cyc) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL missing_beat at cycle %0d: got valid_out=0, required beat due at %0d",
                             cyc, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [WIN-1:0] b;
        rstn     = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rstn = 1'b1;
        idle(2);

        // All +1: B=21, every output 512.
        for (int k = 0; k < NB; k++) apply_beat(fill_beat(DIN'(1)));
        idle(8);

        // All 1000 with one full-scale negative sample in beat 2.
        for (int k = 0; k < NB; k++) begin
            b = fill_beat(DIN'(1000));
            if (k == 2) b[5*DIN +: DIN] = 23'h400000;
            apply_beat(b);
        end
        idle(8);

        // All zero, then all -1.
        for (int k = 0; k < NB; k++) apply_beat(fill_beat('0));
        idle(6);
        for (int k = 0; k < NB; k++) apply_beat(fill_beat(23'h7FFFFF));
        idle(8);

        // Beats separated by idle cycles still form one block.
        for (int k = 0; k < NB; k++) begin
            apply_beat(rand_beat());
            idle($urandom_range(1, 3));
        end
        idle(8);

        // Two blocks with four idle cycles between them.
        for (int k = 0; k < NB; k++) apply_beat(rand_beat());
        idle(4);
        for (int k = 0; k < NB; k++) apply_beat(rand_beat());
        idle(10);

        // Three back-to-back blocks exercise the ping-pong banks.
        for (int k = 0; k < 3 * NB; k++) apply_beat(rand_beat());
        idle(10);

        // Reset in the middle of a block discards the partial block.
        wait_drain(40);
        apply_beat(rand_beat());
        apply_beat(rand_beat());
        @(negedge clk);
        rstn     = 1'b0;
        valid_in = 1'b0;
        blk_idx  = 0;
        repeat (2) @(negedge clk);
        check_reset();
        rstn = 1'b1;
        idle(2);
        for (int k = 0; k < NB; k++) apply_beat(rand_beat());
        idle(8);

        // Samples of 0x1FF800 with B forced to 0: 511 truncated, 512 rounded.
        for (int k = 0; k < NB; k++) begin
            b = fill_beat(23'h1FF800);
            if (k == 0) b[0 +: DIN] = 23'h400000;
            apply_beat(b);
        end
        idle(8);

        // Random blocks with random gaps.
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NB; k++) begin
                apply_beat(rand_beat());
                idle($urandom_range(0, 2));
            end
            idle($urandom_range(0, 5));
        end

        wait_drain(60);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/test_cbfp.md
TEST_CBFP -- requirements
Module: test_cbfp

Interface
REQ-001 SHALL have parameter array_size, default 16: samples per input beat.
REQ-002 SHALL have parameter din_size, default 23: signed input width.
REQ-003 SHALL have parameter dout_size, default 11: signed output width.
REQ-004 SHALL have parameter buffer_depth, default 64: samples per CBFP block; beats per block NB = buffer_depth/array_size (4).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rstn input 1 (asynchronous, active-low).
REQ-006 SHALL have port valid_in input 1: current beat carries valid samples.
REQ-007 SHALL have port din_re_p input array_size x din_size signed: input samples.
REQ-008 SHALL have port dout_re_p output array_size x dout_size signed: scaled output samples.
REQ-009 SHALL have port zero_cnt output NB x din_size: per-beat leading-sign counts of the last completed block, zero-extended.
REQ-010 SHALL have port valid_out output 1: dout_re_p carries valid data.

Function
REQ-011 SHALL define lsc(x) as the number of bits below the MSB equal to the MSB, range 0..din_size-1 (0 and -1 give 22).
REQ-012 SHALL capture a beat only on a rising edge with valid_in=1; a beat counter 0..NB-1 advances per captured beat and wraps; idle cycles between beats do not break the block.
REQ-013 SHALL compute per-beat count g[k] = min lsc over the array_size samples of beat k, at capture.
REQ-014 SHALL compute block count B = min(g[0..NB-1]) when beat NB-1 is captured (edge E).
REQ-015 SHALL load zero_cnt[k]=g[k] for all k at edge E+1 and hold them until the next block completes.
REQ-016 SHALL output beat k of the block at edges E+2+k (k=0..NB-1), valid_out=1 for those NB cycles.
REQ-017 SHALL compute dout = bits [din_size-1 : din_size-dout_size] of (x <<< B), i.e. arithmetic truncation; no overflow is possible.
REQ-018 SHALL drive dout_re_p to 0 whenever valid_out=0.
REQ-019 SHALL ping-pong two buffer_depth banks so that a new block may be captured during the previous block's output; no samples are dropped for back-to-back blocks.
REQ-020 SHALL ignore din_re_p when valid_in=0.

Reset
REQ-021 SHALL, on rstn=0, clear asynchronously: beat counter, bank select, output sequencer, valid_out, dout_re_p, zero_cnt, all to 0.
REQ-022 SHALL discard a partially captured block when reset is asserted mid-block; capture restarts at beat 0 after release.

Configuration
REQ-023 SHALL, with CBFP_ROUND_EN defined, add 2^(din_size-dout_size-1) to (x <<< B) before truncation and saturate the result to +2^(dout_size-1)-1 (1023); without CBFP_ROUND_EN, pure truncation per REQ-017.

Structure
REQ-024 SHALL place default width/depth constants and the NB derivation in package cbfp_pkg.
REQ-025 SHALL implement lsc plus array_size-way min as sub-module cbfp_lsc_min, instantiated once on the capture path.

Verification
REQ-026 SHALL verify reset: after rstn=0, dout_re_p all 0, zero_cnt all 0, valid_out=0.
REQ-027 SHALL verify that 4 beats of all +1 give zero_cnt={21,21,21,21}, B=21 and every dout=512 for 4 cycles starting at E+2.
REQ-028 SHALL verify that 4 beats of all 1000 with one sample -4194304 in beat 2 give zero_cnt={12,12,0,12}, that sample's dout=-1024, and all others 0.
REQ-029 SHALL verify that all-zero input gives zero_cnt all 22 and dout all 0, and that all -1 gives dout all -1024.
REQ-030 SHALL verify that beats separated by idle cycles form one block, and that two blocks with 4 idle cycles between them produce 8 valid output beats in order with correct per-block scaling.
REQ-031 SHALL verify, with CBFP_ROUND_EN, that all samples 0x1FF800 (B=0) give dout=512 (truncation gives 511).
